// File: rtl/arch_defs_pkg.sv
// Shared SAP-2 architecture definitions: the address width and the program
// counter operation encoding used by the control path.
package arch_defs_pkg;

  localparam int ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_BRANCH,
    PC_CALL,
    PC_RET
  } pc_op_e;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the program counter. Pushes when full and pops when
// empty are ignored; the caller reports them as errors.
module pc_return_stack #(
  parameter int ADDR_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_WIDTH-1:0]              push_data,
  output logic [ADDR_WIDTH-1:0]              top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty
);

  localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);
  localparam int IDX_WIDTH   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0]  mem [STACK_DEPTH];
  logic [DEPTH_WIDTH-1:0] depth_q;
  logic [IDX_WIDTH-1:0]   wr_idx;
  logic [IDX_WIDTH-1:0]   rd_idx;
  logic                   push_ok;
  logic                   pop_ok;

  assign full    = (depth_q == DEPTH_WIDTH'(STACK_DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && !full && !pop;
  assign wr_idx  = IDX_WIDTH'(depth_q);
  assign rd_idx  = IDX_WIDTH'(depth_q - DEPTH_WIDTH'(1));
  assign top     = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!reset_n) begin
      depth_q <= '0;
    end else if (pop_ok) begin
      depth_q <= depth_q - DEPTH_WIDTH'(1);
    end else if (push_ok) begin
      depth_q <= depth_q + DEPTH_WIDTH'(1);
    end
  end

  // NOTE: storage has no reset; entries above depth are never observed, and
  // leaving them unreset lets the array map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// SAP-2 program counter with increment, absolute load, signed relative branch
// and a hardware call/return stack with sticky overflow/underflow flags.
module program_counter_stack #(
  parameter int                        ADDR_WIDTH   = arch_defs_pkg::ADDR_WIDTH,
  parameter int                        OFFSET_WIDTH = 8,
  parameter int                        STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0]     RESET_VECTOR = '0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              inc_en,
  input  logic                              load_en,
  input  logic [ADDR_WIDTH-1:0]             load_addr,
  input  logic                              branch_en,
  input  logic [OFFSET_WIDTH-1:0]           branch_offset,
  input  logic                              call_en,
  input  logic                              ret_en,
  input  logic                              err_clear,
  output logic [ADDR_WIDTH-1:0]             counter_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  stack_depth,
  output logic                              stack_full,
  output logic                              stack_empty,
  output logic                              overflow_err,
  output logic                              underflow_err
);

  import arch_defs_pkg::*;

  pc_op_e                op;
  logic [ADDR_WIDTH-1:0] return_addr;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic                  call_fault;
  logic                  ret_fault;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op = PC_HOLD;
    if (ret_en)         op = PC_RET;
    else if (call_en)   op = PC_CALL;
    else if (load_en)   op = PC_LOAD;
    else if (branch_en) op = PC_BRANCH;
    else if (inc_en)    op = PC_INC;
  end

  // The size cast sign-extends or truncates the offset to the PC width; the
  // add then wraps modulo 2^ADDR_WIDTH in either direction.
  assign branch_target = counter_out + ADDR_WIDTH'($signed(branch_offset));
  assign return_addr   = counter_out + ADDR_WIDTH'(1);
  assign call_fault    = (op == PC_CALL) && stack_full;
  assign ret_fault     = (op == PC_RET) && stack_empty;

  pc_return_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (op == PC_CALL),
    .pop       (op == PC_RET),
    .push_data (return_addr),
    .top       (stack_top),
    .depth     (stack_depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_out <= RESET_VECTOR;
    end else begin
      unique case (op)
        PC_INC:    counter_out <= return_addr;
        PC_LOAD:   counter_out <= load_addr;
        PC_BRANCH: counter_out <= branch_target;
        PC_CALL:   if (!stack_full)  counter_out <= load_addr;
        PC_RET:    if (!stack_empty) counter_out <= stack_top;
        default:   counter_out <= counter_out;
      endcase
    end
  end

  // A new fault in the same cycle as err_clear leaves its flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= call_fault || (overflow_err && !err_clear);
      underflow_err <= ret_fault  || (underflow_err && !err_clear);
    end
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack: directed scenarios followed by
// random strobes, all compared against a queue-based reference model.
module tb_program_counter_stack;

  localparam int AW = 4;
  localparam int OW = 8;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          inc_en = 1'b0, load_en = 1'b0, branch_en = 1'b0;
  logic          call_en = 1'b0, ret_en = 1'b0, err_clear = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [OW-1:0] branch_offset = '0;
  logic [AW-1:0] counter_out;
  logic [DW-1:0] stack_depth;
  logic          stack_full, stack_empty, overflow_err, underflow_err;

  program_counter_stack #(
    .ADDR_WIDTH   (AW),
    .OFFSET_WIDTH (OW),
    .STACK_DEPTH  (SD),
    .RESET_VECTOR ('0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .inc_en        (inc_en),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .err_clear     (err_clear),
    .counter_out   (counter_out),
    .stack_depth   (stack_depth),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: PC as an integer, return stack as a queue.
  int m_pc;
  int m_stack[$];
  bit m_oerr, m_uerr;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_oerr = 0;
    m_uerr = 0;
  endtask

  task automatic model_step(input bit r, input bit c, input bit l, input bit b,
                            input bit i, input bit clr, input int la, input int off);
    bit oset = 0;
    bit uset = 0;
    int soff = (off >= 128) ? off - 256 : off;
    if (r) begin
      if (m_stack.size() == 0) uset = 1;
      else m_pc = m_stack.pop_back();
    end else if (c) begin
      if (m_stack.size() == SD) oset = 1;
      else begin
        m_stack.push_back((m_pc + 1) % 16);
        m_pc = la;
      end
    end else if (l) begin
      m_pc = la;
    end else if (b) begin
      m_pc = ((m_pc + soff) % 16 + 16) % 16;
    end else if (i) begin
      m_pc = (m_pc + 1) % 16;
    end
    m_oerr = (m_oerr && !clr) || oset;
    m_uerr = (m_uerr && !clr) || uset;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pc"},    int'(counter_out),   m_pc);
    check({tag, "_depth"}, int'(stack_depth),   m_stack.size());
    check({tag, "_full"},  int'(stack_full),    int'(m_stack.size() == SD));
    check({tag, "_empty"}, int'(stack_empty),   int'(m_stack.size() == 0));
    check({tag, "_oerr"},  int'(overflow_err),  int'(m_oerr));
    check({tag, "_uerr"},  int'(underflow_err), int'(m_uerr));
  endtask

  // Drive one cycle of strobes, let the edge happen, then compare.
  task automatic step(input string tag, input bit r, input bit c, input bit l,
                      input bit b, input bit i, input bit clr,
                      input int la, input int off);
    ret_en = r; call_en = c; load_en = l; branch_en = b; inc_en = i;
    err_clear = clr; load_addr = AW'(la); branch_offset = OW'(off);
    model_step(r, c, l, b, i, clr, la, off);
    @(posedge clk);
    #1;
    ret_en = 0; call_en = 0; load_en = 0; branch_en = 0; inc_en = 0; err_clear = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Increment, load, wrap
    step("inc1", 0, 0, 0, 0, 1, 0, 0, 0);
    step("inc2", 0, 0, 0, 0, 1, 0, 0, 0);
    step("inc3", 0, 0, 0, 0, 1, 0, 0, 0);
    check("tp1_pc3", int'(counter_out), 3);
    step("loadF", 0, 0, 1, 0, 0, 0, 15, 0);
    step("wrap", 0, 0, 0, 0, 1, 0, 0, 0);
    check("tp1_wrap", int'(counter_out), 0);

    // Signed branches, wrapping backward then forward
    step("load2", 0, 0, 1, 0, 0, 0, 2, 0);
    step("br_m3", 0, 0, 0, 1, 0, 0, 0, 8'hFD);
    check("tp2_back", int'(counter_out), 15);
    step("br_p5", 0, 0, 0, 1, 0, 0, 0, 8'h05);
    check("tp2_fwd", int'(counter_out), 4);

    // Nested call/return
    step("load5", 0, 0, 1, 0, 0, 0, 5, 0);
    step("callA", 0, 1, 0, 0, 0, 0, 10, 0);
    step("callC", 0, 1, 0, 0, 0, 0, 12, 0);
    check("tp3_depth2", int'(stack_depth), 2);
    step("ret1", 1, 0, 0, 0, 0, 0, 0, 0);
    check("tp3_retB", int'(counter_out), 11);
    step("ret2", 1, 0, 0, 0, 0, 0, 0, 0);
    check("tp3_ret6", int'(counter_out), 6);
    check("tp3_empty", int'(stack_empty), 1);

    // Overflow on fifth call, clear, then a return still works
    for (int k = 0; k < 5; k++) step("call_ovf", 0, 1, 0, 0, 0, 0, k + 1, 0);
    check("tp4_pc", int'(counter_out), 4);
    check("tp4_oerr", int'(overflow_err), 1);
    step("clr_ovf", 0, 0, 0, 0, 0, 1, 0, 0);
    check("tp4_cleared", int'(overflow_err), 0);
    step("ret_after_ovf", 1, 0, 0, 0, 0, 0, 0, 0);
    check("tp4_ret", int'(counter_out), 4);
    for (int k = 0; k < 3; k++) step("drain", 1, 0, 0, 0, 0, 0, 0, 0);

    // Underflow, and set winning over a simultaneous clear
    step("ret_empty", 1, 0, 0, 0, 0, 0, 0, 0);
    check("tp5_uerr", int'(underflow_err), 1);
    step("ret_clr", 1, 0, 0, 0, 0, 1, 0, 0);
    check("tp5_set_wins", int'(underflow_err), 1);
    step("clr_only", 0, 0, 0, 0, 0, 1, 0, 0);

    // Priority: only the pop happens
    step("load9", 0, 0, 1, 0, 0, 0, 9, 0);
    step("call3", 0, 1, 0, 0, 0, 0, 3, 0);
    step("prio", 1, 1, 1, 0, 1, 0, 7, 0);
    check("tp6_prio_pc", int'(counter_out), 10);

    // Asynchronous reset mid-cycle, observed before any clock edge
    step("call_pre_rst", 0, 1, 0, 0, 0, 0, 13, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Random strobes against the model
    for (int n = 0; n < 400; n++) begin
      step("rand",
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
